// File: rtl/hex_mult_sequencer.sv
// Controller side of the hex multiplier: splits two 2-digit operands into nibbles,
// streams four shifted partial products into the accumulator, then captures the sum.
module hex_mult_sequencer #(
    parameter int NIB = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*NIB-1:0]   op_a,
    input  logic [2*NIB-1:0]   op_b,
    output logic               busy,
    output logic [2:0]         state,
    output logic               adder_en,
    output logic [4*NIB-1:0]   adder_in,
    output logic               done,
    input  logic [4*NIB:0]     adder_out,
    output logic [4*NIB-1:0]   product,
    output logic               product_valid,
    output logic               product_ovf
);

    localparam int OW = 2 * NIB;
    localparam int AW = 4 * NIB;

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        COMPUTE_1 = 3'b001,
        COMPUTE_2 = 3'b010,
        COMPUTE_3 = 3'b011,
        COMPUTE_4 = 3'b100,
        FINISH    = 3'b101
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   a_q, b_q;
    logic            en_d, done_d, load_ops, capture;
    logic [AW-1:0]   in_d;
    logic [AW-1:0]   pp0_in, pp1, pp2, pp3;

    function automatic logic [AW-1:0] ext(input logic [NIB-1:0] x);
        return AW'(x);
    endfunction

    // pp0 comes straight from the inputs because it is issued on the accepting edge,
    // before the operand registers hold the new values.
    assign pp0_in = ext(op_a[NIB-1:0]) * ext(op_b[NIB-1:0]);
    assign pp1    = (ext(a_q[NIB-1:0]) * ext(b_q[OW-1:NIB])) << NIB;
    assign pp2    = (ext(a_q[OW-1:NIB]) * ext(b_q[NIB-1:0])) << NIB;
    assign pp3    = (ext(a_q[OW-1:NIB]) * ext(b_q[OW-1:NIB])) << (2 * NIB);

    assign state   = state_q;
    assign busy    = (state_q != IDLE);
    assign capture = (state_q == FINISH);

    always_comb begin
        state_d  = state_q;
        en_d     = 1'b0;
        in_d     = '0;
        done_d   = 1'b0;
        load_ops = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = COMPUTE_1;
                    en_d     = 1'b1;
                    in_d     = pp0_in;
                    load_ops = 1'b1;
                end
            end
            COMPUTE_1: begin
                state_d = COMPUTE_2;
                en_d    = 1'b1;
                in_d    = pp1;
            end
            COMPUTE_2: begin
                state_d = COMPUTE_3;
                en_d    = 1'b1;
                in_d    = pp2;
            end
            COMPUTE_3: begin
                state_d = COMPUTE_4;
                en_d    = 1'b1;
                in_d    = pp3;
            end
            COMPUTE_4: begin
                state_d = FINISH;
                done_d  = 1'b1;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The accumulator clears on the FINISH edge; both sides see the pre-edge sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            adder_en      <= 1'b0;
            adder_in      <= '0;
            done          <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            product       <= '0;
            product_valid <= 1'b0;
            product_ovf   <= 1'b0;
        end else begin
            state_q       <= state_d;
            adder_en      <= en_d;
            adder_in      <= in_d;
            done          <= done_d;
            product_valid <= capture;
            if (load_ops) begin
                a_q <= op_a;
                b_q <= op_b;
            end
            if (capture) begin
                product     <= adder_out[AW-1:0];
                product_ovf <= adder_out[AW];
            end
        end
    end

endmodule

// File: tb/tb_hex_mult_sequencer.sv
// Directed bench for hex_mult_sequencer with a behavioural 17-bit accumulator
// and a product scoreboard.
module tb_hex_mult_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  op_a, op_b;
    logic        busy;
    logic [2:0]  state;
    logic        adder_en;
    logic [15:0] adder_in;
    logic        done;
    logic [16:0] adder_out;
    logic [15:0] product;
    logic        product_valid;
    logic        product_ovf;

    logic        preload;
    logic [16:0] preload_val;
    logic [16:0] acc;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt = 0;
    logic [15:0] exp_q[$];

    hex_mult_sequencer #(.NIB(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .state(state), .adder_en(adder_en), .adder_in(adder_in),
        .done(done), .adder_out(adder_out), .product(product),
        .product_valid(product_valid), .product_ovf(product_ovf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // accumulator model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         acc <= '0;
        else if (preload)   acc <= preload_val;
        else if (done)      acc <= '0;
        else if (adder_en)  acc <= acc + {1'b0, adder_in};
    end
    assign adder_out = acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (product_valid === 1'b1) begin
            valid_cnt++;
            if (exp_q.size() == 0) check("unexpected_valid", 32'(product), 32'hDEAD);
            else                   check("sb_product", 32'(product), 32'(exp_q.pop_front()));
        end
    end

    // driver: one full operation, checking every cycle of the sequence
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] p0, input logic [15:0] p1,
                         input logic [15:0] p2, input logic [15:0] p3,
                         input logic [15:0] prod, input logic ovf);
        exp_q.push_back(prod);
        @(negedge clk);
        op_a = a; op_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op_a = ~a; op_b = ~b;
        check("c1_state", 32'(state), 1);
        check("c1_busy", 32'(busy), 1);
        check("c1_en", 32'(adder_en), 1);
        check("c1_pp0", 32'(adder_in), 32'(p0));
        @(negedge clk);
        start = 1'b1;
        check("c2_state", 32'(state), 2);
        check("c2_pp1", 32'(adder_in), 32'(p1));
        @(negedge clk);
        start = 1'b0;
        check("c3_state", 32'(state), 3);
        check("c3_pp2", 32'(adder_in), 32'(p2));
        @(negedge clk);
        check("c4_state", 32'(state), 4);
        check("c4_en", 32'(adder_en), 1);
        check("c4_pp3", 32'(adder_in), 32'(p3));
        @(negedge clk);
        check("fin_state", 32'(state), 5);
        check("fin_done", 32'(done), 1);
        check("fin_en", 32'(adder_en), 0);
        check("fin_in", 32'(adder_in), 0);
        @(negedge clk);
        check("out_state", 32'(state), 0);
        check("out_busy", 32'(busy), 0);
        check("out_done", 32'(done), 0);
        check("out_valid", 32'(product_valid), 1);
        check("out_product", 32'(product), 32'(prod));
        check("out_ovf", 32'(product_ovf), 32'(ovf));
        @(negedge clk);
        check("post_valid", 32'(product_valid), 0);
        check("post_state", 32'(state), 0);
        check("post_product_held", 32'(product), 32'(prod));
    endtask

    initial begin
        int base;
        rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
        preload = 1'b0; preload_val = '0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_en", 32'(adder_en), 0);
        check("rst_in", 32'(adder_in), 0);
        check("rst_done", 32'(done), 0);
        check("rst_product", 32'(product), 0);
        check("rst_valid", 32'(product_valid), 0);
        check("rst_ovf", 32'(product_ovf), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_hold_state", 32'(state), 0);

        do_op(8'h12, 8'h34, 16'h0008, 16'h0060, 16'h0040, 16'h0300, 16'h03A8, 1'b0);
        do_op(8'hFF, 8'hFF, 16'h00E1, 16'h0E10, 16'h0E10, 16'hE100, 16'hFE01, 1'b0);
        do_op(8'h00, 8'hAB, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        do_op(8'h01, 8'h01, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 1'b0);

        // start held high: accepts at edges 0, 6 and 12
        base = valid_cnt;
        repeat (3) exp_q.push_back(16'h0100);
        @(negedge clk);
        op_a = 8'h10; op_b = 8'h10; start = 1'b1;
        repeat (7) @(negedge clk);
        check("b2b_restart_state", 32'(state), 1);
        check("b2b_restart_pp0", 32'(adder_in), 0);
        repeat (6) @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("b2b_valid_count", 32'(valid_cnt - base), 3);
        check("b2b_queue_empty", 32'(exp_q.size()), 0);
        check("b2b_idle", 32'(state), 0);

        // reset during COMPUTE_3
        base = valid_cnt;
        op_a = 8'h12; op_b = 8'h34; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_state", 32'(state), 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(state), 0);
        check("mid_rst_en", 32'(adder_en), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_product", 32'(product), 0);
        check("mid_rst_valid", 32'(product_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("mid_rst_no_valid", 32'(valid_cnt - base), 0);
        do_op(8'h12, 8'h34, 16'h0008, 16'h0060, 16'h0040, 16'h0300, 16'h03A8, 1'b0);

        // dirty accumulator preload
        preload_val = 17'h10000; preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        do_op(8'h01, 8'h01, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 1'b1);
        check("acc_cleared", 32'(acc), 0);
        check("final_queue_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
